fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage feeding the decoder/control unit: owns the PC register and issues word requests to instruction memory.
- Buffers returned instructions in a 2-entry FIFO and presents them with a valid/ready handshake.
- Accepts PC redirects for taken branches, jal and jalr; each redirect flushes all younger fetched work.

Parameters:
- DATA_WIDTH, 32, instruction/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; fixed at 2, other values unsupported.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- imem_req_o  output  1  fetch request, one-cycle pulse.
- imem_addr_o  output  DATA_WIDTH  request address, word aligned.
- imem_rvalid_i  input  1  response valid; at most one response per request, latency >=1 cycle.
- imem_rdata_i  input  DATA_WIDTH  response instruction.
- PCSrc_i  input  1  redirect strobe from control unit.
- PCTarget_i  input  DATA_WIDTH  redirect target; bits [1:0] are ignored and treated as 0.
- Instr_o  output  DATA_WIDTH  FIFO head instruction.
- PC_o  output  DATA_WIDTH  PC of Instr_o.
- PCPlus4_o  output  DATA_WIDTH  PC_o + 4.
- Valid_o  output  1  head entry valid.
- Ready_i  input  1  downstream accepts head when Valid_o is high.

Behaviour:
- Reset (async assert, sync deassert use):
  - All outputs are 0; FIFO is empty.
  - fetch_pc = RESET_PC; state is IDLE.
- States:
  - IDLE: first cycle out of reset; goes to ISSUE next cycle.
  - ISSUE: issues a request when (fifo_count + outstanding) < 2. Drives imem_req_o=1 and imem_addr_o=fetch_pc, then fetch_pc += 4 and goes to WAIT. If there is no space, it stays in ISSUE.
  - WAIT: on imem_rvalid_i, push {rdata, pc}, then go to ISSUE.
  - KILL: one response is still outstanding after a redirect. On imem_rvalid_i, discard the data and go to ISSUE.
- Outstanding requests: at most 1.
- Latency: Valid_o rises no earlier than 1 cycle after imem_rvalid_i. The FIFO is registered, so there is no combinational rdata-to-Instr_o path.
- Handshake:
  - Pop when Valid_o && Ready_i.
  - Instr_o, PC_o and Valid_o stay stable while Valid_o && !Ready_i, unless a redirect occurs.
- Simultaneous push and pop with count=2 is illegal by construction: the space check reserves the slot.
- Push and pop in the same cycle leave the count unchanged.
- Redirect (PCSrc_i=1, highest priority):
  - The same-cycle pop still counts as consumed.
  - FIFO is flushed; next-cycle Valid_o=0.
  - fetch_pc = {PCTarget_i[31:2], 2'b00}.
  - Any same-cycle imem_rvalid_i data is dropped.
  - With a request outstanding and no same-cycle rvalid, go to KILL; otherwise go to ISSUE.
  - No request is issued in the redirect cycle.
- Redirect while in KILL: update fetch_pc and remain in KILL.
- PC wrap: fetch_pc + 4 wraps modulo 2^32 without a flag.
- Reset mid-request: the state is dropped, and a late imem_rvalid_i in IDLE is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output ports fetch_count_o[31:0] and bubble_count_o[31:0], both reset to 0 and wrapping.
  - fetch_count_o increments on each handshake (Valid_o && Ready_i).
  - bubble_count_o increments on each cycle with Ready_i && !Valid_o.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package (riscv_pkg):
  - fetch_state_t enum {IDLE, ISSUE, WAIT, KILL}.
  - RESET_PC_DEFAULT constant.
  - INSTR_NOP constant 32'h0000_0013.
- One natural sub-module, fetch_fifo: 2-entry {instr, pc} FIFO with push, pop, flush, count, full and empty.

Test Plan:
- Reset, memory at latency 1 returning 0x00500093 @0x0, 0x00A00113 @0x4, Ready_i=1 → requests to 0x0, 0x4, 0x8; Valid_o with PC_o 0x0 then 0x4, PCPlus4_o 0x4 then 0x8, Instr_o as stored.
- Ready_i held 0 from start → exactly 2 responses buffered, imem_req_o stays 0. Instr_o/PC_o stay frozen at 0x0 until Ready_i=1, then requests resume at 0x8.
- Redirect PCSrc_i=1, PCTarget_i=0x40 while a request to 0x8 is outstanding → KILL; the 0x8 response is discarded. The next request goes to 0x40, and the first valid has PC_o=0x40.
- Redirect on the same cycle as imem_rvalid_i, target 0x103 → rdata dropped, next request addr 0x100, no Valid_o between.
- Memory latency 3, Ready_i toggling every cycle → no lost or duplicated PCs; the PC sequence is strictly +4; at most 1 outstanding request at all times.
- With FETCH_PERF_CNT_EN: 5 handshakes and 3 ready-but-empty cycles → fetch_count_o=5, bubble_count_o=3; rst_ni pulse mid-run → both counters read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, KILL} fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {instr, pc} buffer; slot 0 is always the head, so outputs come straight from flops.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] push_instr,
  input  logic [DATA_WIDTH-1:0] push_pc,
  output logic [DATA_WIDTH-1:0] head_instr,
  output logic [DATA_WIDTH-1:0] head_pc,
  output logic [1:0]            count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] instr_q [2];
  logic [DATA_WIDTH-1:0] pc_q    [2];
  logic                  do_pop;
  logic                  do_push;
  logic [1:0]            slot;

  assign full       = (count == DEPTH);
  assign empty      = (count == 2'd0);
  assign head_instr = instr_q[0];
  assign head_pc    = pc_q[0];
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign slot       = count - {1'b0, do_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
    end else if (flush) begin
      count      <= 2'd0;
      instr_q[0] <= '0;
      pc_q[0]    <= '0;
    end else begin
      if (do_pop) begin
        instr_q[0] <= instr_q[1];
        pc_q[0]    <= pc_q[1];
      end
      // Later assignment wins, so a push into slot 0 overrides the shift.
      if (do_push) begin
        if (slot == 2'd0) begin
          instr_q[0] <= push_instr;
          pc_q[0]    <= push_pc;
        end else begin
          instr_q[1] <= push_instr;
          pc_q[1]    <= push_pc;
        end
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem requests, 2-entry buffer, redirects.
// Optional performance counters enabled by FETCH_PERF_CNT_EN.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  PCSrc_i,
  input  logic [DATA_WIDTH-1:0] PCTarget_i,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] PCPlus4_o,
  output logic                  Valid_o,
  input  logic                  Ready_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_count_o,
  output logic [31:0]           bubble_count_o
`endif
);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [1:0]            fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  outstanding;
  logic [2:0]            occupancy;
  logic                  space;
  logic                  unused_target_lsbs;

  assign unused_target_lsbs = ^PCTarget_i[1:0];

  assign outstanding = (state == WAIT) || (state == KILL);
  assign occupancy   = {1'b0, fifo_count} + {2'b00, outstanding};
  assign space       = occupancy < 3'(FIFO_DEPTH);
  assign pop         = Valid_o && Ready_i;
  // imem_addr_o still holds the address of the outstanding request.
  assign push        = (state == WAIT) && imem_rvalid_i && !PCSrc_i && !fifo_full;
  assign Valid_o     = !fifo_empty;
  assign PCPlus4_o   = Valid_o ? PC_o + DATA_WIDTH'(4) : '0;

  fetch_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (push),
    .pop       (pop),
    .flush     (PCSrc_i),
    .push_instr(imem_rdata_i),
    .push_pc   (imem_addr_o),
    .head_instr(Instr_o),
    .head_pc   (PC_o),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
    end else begin
      imem_req_o <= 1'b0;
      if (PCSrc_i) begin
        fetch_pc <= {PCTarget_i[DATA_WIDTH-1:2], 2'b00};
        state    <= (outstanding && !imem_rvalid_i) ? KILL : ISSUE;
      end else begin
        unique case (state)
          IDLE:  state <= ISSUE;
          ISSUE: if (space) begin
            imem_req_o  <= 1'b1;
            imem_addr_o <= fetch_pc;
            fetch_pc    <= fetch_pc + DATA_WIDTH'(4);
            state       <= WAIT;
          end
          WAIT:  if (imem_rvalid_i) state <= ISSUE;
          KILL:  if (imem_rvalid_i) state <= ISSUE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_count_o  <= 32'd0;
      bubble_count_o <= 32'd0;
    end else begin
      if (pop)                 fetch_count_o  <= fetch_count_o + 32'd1;
      if (Ready_i && !Valid_o) bubble_count_o <= bubble_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: imem responder, directed scenarios and randomized redirect/ready traffic.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        PCSrc_i = 1'b0;
  logic [31:0] PCTarget_i = '0;
  logic [31:0] Instr_o, PC_o, PCPlus4_o;
  logic        Valid_o;
  logic        Ready_i = 1'b1;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_o, bubble_count_o;
`endif

  fetch_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .PCSrc_i(PCSrc_i), .PCTarget_i(PCTarget_i),
    .Instr_o(Instr_o), .PC_o(PC_o), .PCPlus4_o(PCPlus4_o),
    .Valid_o(Valid_o), .Ready_i(Ready_i)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count_o(fetch_count_o), .bubble_count_o(bubble_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int fails  = 0;
  int lat = 1;
  int pend = 0;
  logic [31:0] pend_addr = '0;
  int req_total = 0;

  logic [31:0] exp_q[$];
  logic [31:0] tail_pc, exp_req;
  logic        prev_stall = 1'b0, prev_redir = 1'b0;
  logic [31:0] prev_instr, prev_pc;
  logic [31:0] m_fetch, m_bubble;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return {a[7:0], a[31:8]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected delivery stream: contiguous word PCs from the last reset/redirect target.
  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    tail_pc = start;
    exp_req = start;
    while (exp_q.size() < 8) begin
      exp_q.push_back(tail_pc);
      tail_pc = tail_pc + 32'd4;
    end
  endtask

  // imem model: fixed latency per request, data a pure function of the address.
  initial forever begin
    @(posedge clk_i); #1;
    imem_rvalid_i = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_fn(pend_addr);
      end
    end
    if (imem_req_o) begin
      chk("one_outstanding", 32'(pend), 32'd0);
      req_total++;
      pend = lat;
      pend_addr = imem_addr_o;
    end
  end

  // Monitor: compares every handshake and request against the expected stream.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      restart_stream(32'h0);
      prev_stall = 1'b0;
      prev_redir = 1'b0;
      m_fetch  = '0;
      m_bubble = '0;
    end else begin
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count_o, m_fetch);
      chk("bubble_count", bubble_count_o, m_bubble);
`endif
      if (prev_redir) begin
        chk("valid_after_redirect", 32'(Valid_o), 32'd0);
        chk("req_after_redirect", 32'(imem_req_o), 32'd0);
      end
      if (imem_req_o) begin
        chk("req_addr", imem_addr_o, exp_req);
        exp_req = exp_req + 32'd4;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(Valid_o), 32'd1);
        chk("stall_instr", Instr_o, prev_instr);
        chk("stall_pc", PC_o, prev_pc);
      end
      if (Valid_o && Ready_i) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pc", PC_o, e);
        chk("instr", Instr_o, mem_fn(e));
        chk("pcplus4", PCPlus4_o, e + 32'd4);
        exp_q.push_back(tail_pc);
        tail_pc = tail_pc + 32'd4;
        m_fetch = m_fetch + 32'd1;
      end
      if (Ready_i && !Valid_o) m_bubble = m_bubble + 32'd1;
      prev_stall = Valid_o && !Ready_i && !PCSrc_i;
      prev_redir = PCSrc_i;
      prev_instr = Instr_o;
      prev_pc    = PC_o;
      if (PCSrc_i) restart_stream({PCTarget_i[31:2], 2'b00});
    end
  end

  task automatic tick();
    @(posedge clk_i); #2;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, 32'(Valid_o), 32'd0);
    chk({tag, "_req"}, 32'(imem_req_o), 32'd0);
    chk({tag, "_addr"}, imem_addr_o, 32'd0);
    chk({tag, "_instr"}, Instr_o, 32'd0);
    chk({tag, "_pc"}, PC_o, 32'd0);
    chk({tag, "_pcplus4"}, PCPlus4_o, 32'd0);
  endtask

  task automatic wait_valid(input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (Valid_o) begin found = 1'b1; break; end
      tick();
    end
  endtask

  task automatic random_run(input int cycles, input bit redirects);
    for (int i = 0; i < cycles; i++) begin
      if (i % 100 == 0) lat = $urandom_range(1, 4);
      Ready_i = ($urandom_range(0, 3) != 0);
      PCSrc_i = redirects && ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0: PCTarget_i = $urandom;
        1: PCTarget_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: PCTarget_i = 32'($urandom_range(0, 255));
      endcase
      tick();
    end
    PCSrc_i = 1'b0;
  endtask

  initial begin
    logic found;
    repeat (2) @(posedge clk_i);
    #2;
    chk_reset_outs("por");
    rst_ni = 1'b1;

    // Latency 1, always ready.
    wait_valid(30, found);
    chk("t1_found", 32'(found), 32'd1);
    chk("t1_pc", PC_o, 32'h0);
    chk("t1_instr", Instr_o, 32'h0050_0093);
    repeat (10) tick();

    // Ready held low: buffer fills with two entries, then requests stop.
    rst_ni = 1'b0;
    Ready_i = 1'b0;
    tick();
    req_total = 0;
    rst_ni = 1'b1;
    repeat (20) tick();
    chk("t2_req_total", 32'(req_total), 32'd2);
    chk("t2_valid", 32'(Valid_o), 32'd1);
    chk("t2_pc", PC_o, 32'h0);

    // Redirect to 0x40 while the 0x8 request is outstanding.
    lat = 3;
    Ready_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (imem_req_o && imem_addr_o == 32'h8) begin found = 1'b1; break; end
      tick();
    end
    chk("t3_req8_seen", 32'(found), 32'd1);
    PCSrc_i = 1'b1;
    PCTarget_i = 32'h40;
    tick();
    PCSrc_i = 1'b0;
    wait_valid(40, found);
    chk("t3_found", 32'(found), 32'd1);
    chk("t3_pc", PC_o, 32'h40);

    // Redirect coinciding with a response; target low bits ignored.
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (imem_rvalid_i) begin found = 1'b1; break; end
      tick();
    end
    chk("t4_rvalid_seen", 32'(found), 32'd1);
    PCSrc_i = 1'b1;
    PCTarget_i = 32'h103;
    tick();
    PCSrc_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_o) begin found = 1'b1; break; end
      tick();
    end
    chk("t4_req_seen", 32'(found), 32'd1);
    chk("t4_req_addr", imem_addr_o, 32'h100);
    wait_valid(20, found);
    chk("t4_pc", PC_o, 32'h100);

    // Latency 3 with Ready toggling every cycle.
    lat = 3;
    for (int i = 0; i < 300; i++) begin
      Ready_i = ~Ready_i;
      tick();
    end

    // Random latency, ready and redirects (including targets near the wrap point).
    random_run(1500, 1'b1);

    // Reset while a request is in flight; the late response lands in IDLE.
    lat = 1;
    Ready_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_o && imem_addr_o != 32'h0) begin found = 1'b1; break; end
      tick();
    end
    chk("t6_req_seen", 32'(found), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk_reset_outs("mid");
    tick();
    rst_ni = 1'b1;
    wait_valid(30, found);
    chk("t6_pc", PC_o, 32'h0);
    chk("t6_instr", Instr_o, 32'h0050_0093);
    random_run(300, 1'b1);

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
